// File: rtl/tern_pkg.sv
// Shared definitions for the tern_sched engine scheduler: data widths,
// command opcode nibbles, the requester op encoding and the FSM states.
package tern_pkg;

    localparam int IN_W  = 16;
    localparam int CFG_W = 7;
    localparam int CNT_W = 4;

    localparam logic [3:0] NIB_LOAD = 4'hA;
    localparam logic [3:0] NIB_MULT = 4'hF;
    localparam logic [3:0] NIB_OUT  = 4'hB;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_MULT = 2'd1,
        OP_OUT  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

    // Command word placed on the engine bus in the ISSUE cycle.
    // A reserved opcode never reaches the engine, so it maps to zero.
    function automatic logic [IN_W-1:0] cmd_word(input op_e op,
                                                 input logic [CFG_W-1:0] cfg,
                                                 input logic [CNT_W-1:0] cnt);
        logic [IN_W-1:0] w;
        case (op)
            OP_LOAD: w = {NIB_LOAD, cfg, 1'b0, cnt};
            OP_MULT: w = {NIB_MULT, 8'h00, cnt};
            OP_OUT:  w = {NIB_OUT, 12'h000};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tern_rr_arb.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; it moves to the other requester whenever a grant is accepted.
module tern_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // One-hot grant: a lone request wins outright, a tie goes to the pointer.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // Favour the requester that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule

// File: rtl/tern_sched.sv
// tern_sched: arbitrates two requesters onto a single non-stallable engine.
// Each accepted command is issued as one command word, optionally followed
// by a payload stream, a pipeline drain, or a wait for engine completion.
// Every output is a register loaded with the value belonging to the state
// being entered, so outputs line up with the state they describe.
module tern_sched
    import tern_pkg::*;
#(
    parameter int DRAIN   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [3:0]          req_op,
    input  logic [2*CFG_W-1:0]  req_cfg,
    input  logic [2*CNT_W-1:0]  req_cnt,
    output logic [1:0]          req_ready,
    input  logic [1:0]          dat_valid,
    input  logic [2*IN_W-1:0]   dat_word,
    output logic [1:0]          dat_ready,
    output logic [IN_W-1:0]     eng_word,
    input  logic                eng_done,
    output logic                grant,
    output logic                busy,
    output logic                err
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next;
    op_e              r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_beat;
    logic [7:0]       r_tick;
    logic             r_grant;
    logic             r_busy;
    logic             r_err;
    logic [IN_W-1:0]  r_eng_word;
    logic [1:0]       r_req_ready;
    logic [1:0]       r_dat_ready;

    logic [1:0]       w_gnt_oh;
    logic             w_accept;
    logic             w_sel;
    op_e              w_sel_op;
    logic [CFG_W-1:0] w_sel_cfg;
    logic [CNT_W-1:0] w_sel_cnt;
    logic             w_cur_vld;
    logic [IN_W-1:0]  w_cur_word;
    logic             w_wd_expired;
    logic             w_set_err;
    logic [IN_W-1:0]  w_eng_word;
    logic [1:0]       w_dat_ready;

    tern_rr_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req_valid),
        .i_accept (w_accept),
        .o_gnt    (w_gnt_oh)
    );

    // Pick out the arbitration winner's command and the owner's payload lane.
    always_comb begin
        w_sel      = w_gnt_oh[1];
        w_sel_op   = op_e'(w_sel ? req_op[3:2] : req_op[1:0]);
        w_sel_cfg  = w_sel ? req_cfg[2*CFG_W-1:CFG_W] : req_cfg[CFG_W-1:0];
        w_sel_cnt  = w_sel ? req_cnt[2*CNT_W-1:CNT_W] : req_cnt[CNT_W-1:0];
        w_cur_vld  = r_grant ? dat_valid[1] : dat_valid[0];
        w_cur_word = r_grant ? dat_word[2*IN_W-1:IN_W] : dat_word[IN_W-1:0];
    end

    // Next state plus the output values that belong to that next state.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_set_err    = 1'b0;
        w_eng_word   = '0;
        w_dat_ready  = 2'b00;
        w_wd_expired = (r_tick == WD_LAST);

        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (r_op)
                    OP_LOAD, OP_MULT: w_next = ST_STREAM;
                    OP_OUT:           w_next = ST_WAIT;
                    default: begin
                        w_next    = ST_IDLE;
                        w_set_err = 1'b1;
                    end
                endcase
            end
            ST_STREAM: begin
                if (r_op == OP_MULT) begin
                    if (r_beat == r_cnt) begin
                        w_next = (DRAIN == 0) ? ST_IDLE : ST_DRAIN;
                    end
                end else if (eng_done) begin
                    w_next = ST_IDLE;
                end else if (w_wd_expired) begin
                    w_next    = ST_IDLE;
                    w_set_err = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_tick == DRAIN_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    w_next = ST_IDLE;
                end else if (w_wd_expired) begin
                    w_next    = ST_IDLE;
                    w_set_err = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        // The engine cannot stall: a missing beat still goes out, as zero.
        if (w_next == ST_ISSUE) begin
            w_eng_word = cmd_word(w_sel_op, w_sel_cfg, w_sel_cnt);
        end else if (w_next == ST_STREAM) begin
            w_eng_word           = w_cur_vld ? w_cur_word : '0;
            w_dat_ready[r_grant] = w_cur_vld;
            if (!w_cur_vld) begin
                w_set_err = 1'b1;
            end
        end
    end

    // State, latched command context, beat counter and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_cnt   <= '0;
            r_grant <= 1'b0;
            r_beat  <= '0;
            r_tick  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= w_sel_op;
                r_cnt   <= w_sel_cnt;
                r_grant <= w_sel;
            end
            if (r_state != ST_STREAM) begin
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_next != r_state) begin
                r_tick <= '0;
            end else if (r_tick != 8'hFF) begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    // Registered outputs; err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_eng_word  <= '0;
            r_req_ready <= 2'b00;
            r_dat_ready <= 2'b00;
        end else begin
            r_busy      <= (w_next != ST_IDLE);
            r_eng_word  <= w_eng_word;
            r_req_ready <= w_accept ? w_gnt_oh : 2'b00;
            r_dat_ready <= w_dat_ready;
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign eng_word  = r_eng_word;
    assign req_ready = r_req_ready;
    assign dat_ready = r_dat_ready;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
